// File: rtl/io_port_pkg.sv
// Port map and defaults shared by the CPU I/O port controller.
package io_port_pkg;

    localparam logic [7:0] INP0       = 8'd0;
    localparam logic [7:0] INP1       = 8'd1;
    localparam logic [7:0] INP2       = 8'd2;
    localparam logic [7:0] SHIFT_AMT  = 8'd2;
    localparam logic [7:0] SHIFT_RES  = 8'd3;
    localparam logic [7:0] SOUND1     = 8'd3;
    localparam logic [7:0] SHIFT_DATA = 8'd4;
    localparam logic [7:0] SOUND2     = 8'd5;
    localparam logic [7:0] WATCHDOG   = 8'd6;

    localparam logic [15:0] WDOG_LIMIT_DEFAULT = 16'd60000;

endpackage

// File: rtl/sound_port_latch.sv
// Sound output port: holds the last written level and pulses the bits that
// went 0->1 on that write for one cycle.
module sound_port_latch #(
    parameter int XLEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] level,
    output logic [XLEN-1:0] trig
);

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            trig  <= '0;
        end else begin
            // Edge detect against the level as it stood before this write.
            trig <= wr_en ? (wdata & ~level) : '0;
            if (wr_en) begin
                level <= wdata;
            end
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// CPU IN/OUT port controller: switch inputs, shift-register interface,
// two sound latches and a port-6 kicked watchdog.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int          XLEN       = 8,
    parameter logic [15:0] WDOG_LIMIT = WDOG_LIMIT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      port_addr,
    input  logic [XLEN-1:0] port_wdata,
    input  logic            port_wr,
    input  logic            port_rd,
    output logic [XLEN-1:0] port_rdata,
    output logic            port_rdata_valid,
    input  logic [XLEN-1:0] inp0,
    input  logic [XLEN-1:0] inp1,
    input  logic [XLEN-1:0] inp2,
    output logic [XLEN-1:0] shift_wdata,
    output logic            shift_wenable,
    output logic [2:0]      shift_amount,
    input  logic [XLEN-1:0] shift_result,
    output logic [XLEN-1:0] sound1,
    output logic [XLEN-1:0] sound2,
    output logic [XLEN-1:0] sound1_trig,
    output logic [XLEN-1:0] sound2_trig,
    output logic            wdog_timeout
);

    // Handshake: port_wr and port_rd are single-cycle strobes with no
    // back-pressure. Every strobe is accepted on the edge it is sampled, a
    // read and a write in the same cycle are both serviced, and each read
    // yields exactly one port_rdata_valid pulse on the following cycle.

    logic            wr_shift_amt;
    logic            wr_shift_data;
    logic            wr_sound1;
    logic            wr_sound2;
    logic            wr_wdog;
    logic [XLEN-1:0] rd_mux;
    logic [15:0]     wdog_cnt;
    logic [15:0]     wdog_cnt_next;

    assign wr_shift_amt  = port_wr && (port_addr == SHIFT_AMT);
    assign wr_shift_data = port_wr && (port_addr == SHIFT_DATA);
    assign wr_sound1     = port_wr && (port_addr == SOUND1);
    assign wr_sound2     = port_wr && (port_addr == SOUND2);
    assign wr_wdog       = port_wr && (port_addr == WATCHDOG);

    always_comb begin
        rd_mux = '0;
        case (port_addr)
            INP0:      rd_mux = inp0;
            INP1:      rd_mux = inp1;
            INP2:      rd_mux = inp2;
            SHIFT_RES: rd_mux = shift_result;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_rdata       <= '0;
            port_rdata_valid <= 1'b0;
        end else begin
            port_rdata_valid <= port_rd;
            if (port_rd) begin
                port_rdata <= rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_amount  <= 3'd0;
            shift_wdata   <= '0;
            shift_wenable <= 1'b0;
        end else begin
            shift_wenable <= wr_shift_data;
            if (wr_shift_amt) begin
                shift_amount <= port_wdata[2:0];
            end
            if (wr_shift_data) begin
                shift_wdata <= port_wdata;
            end
        end
    end

    sound_port_latch #(.XLEN(XLEN)) u_sound1 (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_sound1),
        .wdata (port_wdata),
        .level (sound1),
        .trig  (sound1_trig)
    );

    sound_port_latch #(.XLEN(XLEN)) u_sound2 (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_sound2),
        .wdata (port_wdata),
        .level (sound2),
        .trig  (sound2_trig)
    );

    // Counter saturates at the limit so the timeout flag stays sticky.
    assign wdog_cnt_next = (wdog_cnt == WDOG_LIMIT) ? wdog_cnt : wdog_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt     <= 16'd0;
            wdog_timeout <= 1'b0;
        end else if (wr_wdog) begin
            wdog_cnt     <= 16'd0;
            wdog_timeout <= 1'b0;
        end else begin
            wdog_cnt <= wdog_cnt_next;
            if (wdog_cnt_next == WDOG_LIMIT) begin
                wdog_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_io_port_ctrl;

    localparam int          XLEN  = 8;
    localparam logic [15:0] LIMIT = 16'd10;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]      port_addr;
    logic [XLEN-1:0] port_wdata;
    logic            port_wr;
    logic            port_rd;
    logic [XLEN-1:0] port_rdata;
    logic            port_rdata_valid;
    logic [XLEN-1:0] inp0, inp1, inp2;
    logic [XLEN-1:0] shift_wdata;
    logic            shift_wenable;
    logic [2:0]      shift_amount;
    logic [XLEN-1:0] shift_result;
    logic [XLEN-1:0] sound1, sound2, sound1_trig, sound2_trig;
    logic            wdog_timeout;

    io_port_ctrl #(.XLEN(XLEN), .WDOG_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .rst              (rst),
        .port_addr        (port_addr),
        .port_wdata       (port_wdata),
        .port_wr          (port_wr),
        .port_rd          (port_rd),
        .port_rdata       (port_rdata),
        .port_rdata_valid (port_rdata_valid),
        .inp0             (inp0),
        .inp1             (inp1),
        .inp2             (inp2),
        .shift_wdata      (shift_wdata),
        .shift_wenable    (shift_wenable),
        .shift_amount     (shift_amount),
        .shift_result     (shift_result),
        .sound1           (sound1),
        .sound2           (sound2),
        .sound1_trig      (sound1_trig),
        .sound2_trig      (sound2_trig),
        .wdog_timeout     (wdog_timeout)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] exp_q[$];

    // Behavioural reference: plain variables updated from the port rules.
    logic [2:0]      m_amt;
    logic [XLEN-1:0] m_swd, m_s1, m_s2, m_t1, m_t2, m_rdata;
    logic            m_swen, m_rvalid, m_wto;
    int              m_wcnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [XLEN-1:0] rv;
        if (rst) begin
            m_amt = '0; m_swd = '0; m_s1 = '0; m_s2 = '0; m_t1 = '0; m_t2 = '0;
            m_rdata = '0; m_swen = 1'b0; m_rvalid = 1'b0; m_wto = 1'b0; m_wcnt = 0;
            exp_q.delete();
        end else begin
            m_t1 = '0;
            m_t2 = '0;
            m_swen = 1'b0;
            if (port_wr) begin
                case (port_addr)
                    8'd2: m_amt = port_wdata[2:0];
                    8'd3: begin m_t1 = port_wdata & ~m_s1; m_s1 = port_wdata; end
                    8'd4: begin m_swd = port_wdata; m_swen = 1'b1; end
                    8'd5: begin m_t2 = port_wdata & ~m_s2; m_s2 = port_wdata; end
                    8'd6: begin m_wcnt = 0; m_wto = 1'b0; end
                    default: ;
                endcase
            end
            if (!(port_wr && port_addr == 8'd6)) begin
                if (m_wcnt < int'(LIMIT)) m_wcnt++;
                if (m_wcnt == int'(LIMIT)) m_wto = 1'b1;
            end
            m_rvalid = port_rd;
            if (port_rd) begin
                case (port_addr)
                    8'd0:    rv = inp0;
                    8'd1:    rv = inp1;
                    8'd2:    rv = inp2;
                    8'd3:    rv = shift_result;
                    default: rv = '0;
                endcase
                m_rdata = rv;
                exp_q.push_back(rv);
            end
        end
    endtask

    task automatic check_all();
        logic [XLEN-1:0] exp_rd;
        check("shift_amount", shift_amount, m_amt);
        check("shift_wdata", shift_wdata, m_swd);
        check("shift_wenable", shift_wenable, m_swen);
        check("sound1", sound1, m_s1);
        check("sound2", sound2, m_s2);
        check("sound1_trig", sound1_trig, m_t1);
        check("sound2_trig", sound2_trig, m_t2);
        check("port_rdata", port_rdata, m_rdata);
        check("port_rdata_valid", port_rdata_valid, m_rvalid);
        check("wdog_timeout", wdog_timeout, m_wto);
        if (port_rdata_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_rd = exp_q.pop_front();
                check("sb_rdata", port_rdata, exp_rd);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are set beforehand; one rising edge, then sample 1 ns later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic r, input logic wr, input logic rd,
                         input logic [7:0] addr, input logic [XLEN-1:0] wd);
        rst        = r;
        port_wr    = wr;
        port_rd    = rd;
        port_addr  = addr;
        port_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'd0, '0);
        step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic            wr;
        logic            rd;
        logic [7:0]      addr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] sres;
        logic [2:0]      e_amt;
        logic [XLEN-1:0] e_swd;
        logic            e_swen;
        logic [XLEN-1:0] e_s1;
        logic [XLEN-1:0] e_t1;
        logic [XLEN-1:0] e_rdata;
        logic            e_rvalid;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    initial begin
        //                wr    rd    addr   wdata  in1    sres   amt   swd    swen  s1     t1     rdata  rv
        vecs[0]  = '{1'b1, 1'b0, 8'd2, 8'hFD, 8'h81, 8'h3C, 3'd5, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'd4, 8'hAB, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 8'd0, 8'h00, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'd3, 8'h05, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h05, 8'h05, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'd3, 8'h0F, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h0F, 8'h0A, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 8'h00, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'd1, 8'h00, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h0F, 8'h00, 8'h81, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'd3, 8'h00, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h0F, 8'h00, 8'h3C, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'd9, 8'h00, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'd0, 8'h00, 8'h81, 8'h3C, 3'd5, 8'hAB, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 8'd4, 8'h01, 8'h81, 8'h3C, 3'd5, 8'h01, 1'b1, 8'h0F, 8'h00, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 8'd4, 8'h02, 8'h81, 8'h3C, 3'd5, 8'h02, 1'b1, 8'h0F, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'd0, 8'h00, 8'h81, 8'h3C, 3'd5, 8'h02, 1'b0, 8'h0F, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 8'd2, 8'h0A, 8'h81, 8'h3C, 3'd2, 8'h02, 1'b0, 8'h0F, 8'h00, 8'h20, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 8'd3, 8'hF0, 8'h81, 8'h5A, 3'd2, 8'h02, 1'b0, 8'hF0, 8'hF0, 8'h5A, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'd7, 8'hFF, 8'h81, 8'h3C, 3'd2, 8'h02, 1'b0, 8'hF0, 8'h00, 8'h5A, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 8'd0, 8'hFF, 8'h81, 8'h3C, 3'd2, 8'h02, 1'b0, 8'hF0, 8'h00, 8'h5A, 1'b0};
    end

    // ---------------- test sequence ----------------
    initial begin
        inp0 = 8'h10;
        inp1 = 8'h00;
        inp2 = 8'h20;
        shift_result = 8'h00;
        drive(1'b1, 1'b0, 1'b0, 8'd0, '0);
        #1;

        // Reset state
        step();
        step();
        check("reset_rdata", port_rdata, 32'h0);
        check("reset_valid", port_rdata_valid, 32'h0);
        check("reset_swen", shift_wenable, 32'h0);
        check("reset_wdog", wdog_timeout, 32'h0);

        // Directed table
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            inp1         = vecs[i].in1;
            shift_result = vecs[i].sres;
            step();
            check($sformatf("vec%0d_amt", i), shift_amount, vecs[i].e_amt);
            check($sformatf("vec%0d_swd", i), shift_wdata, vecs[i].e_swd);
            check($sformatf("vec%0d_swen", i), shift_wenable, vecs[i].e_swen);
            check($sformatf("vec%0d_s1", i), sound1, vecs[i].e_s1);
            check($sformatf("vec%0d_t1", i), sound1_trig, vecs[i].e_t1);
            check($sformatf("vec%0d_rdata", i), port_rdata, vecs[i].e_rdata);
            check($sformatf("vec%0d_rvalid", i), port_rdata_valid, vecs[i].e_rvalid);
        end

        // Watchdog: times out on the 10th cycle after reset and stays high
        drive(1'b1, 1'b0, 1'b0, 8'd0, '0);
        step();
        for (int k = 1; k <= 14; k++) begin
            idle();
            check($sformatf("wdog_after_%0d", k), wdog_timeout, (k >= 10) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b1, 1'b0, 8'd6, 8'h00);
        step();
        check("wdog_kick_clears", wdog_timeout, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            idle();
            check($sformatf("wdog_rearm_%0d", k), wdog_timeout, (k >= 10) ? 32'd1 : 32'd0);
        end

        // Reset overrides a concurrent OUT 4 and IN
        drive(1'b0, 1'b1, 1'b0, 8'd4, 8'hAB);
        step();
        drive(1'b1, 1'b1, 1'b1, 8'd4, 8'h55);
        step();
        check("rst_ovr_swen", shift_wenable, 32'd0);
        check("rst_ovr_swd", shift_wdata, 32'h00);
        check("rst_ovr_valid", port_rdata_valid, 32'd0);
        idle();
        check("rst_ovr_swen_after", shift_wenable, 32'd0);
        check("rst_ovr_valid_after", port_rdata_valid, 32'd0);

        // Sound 2 rising-edge pulses
        drive(1'b0, 1'b1, 1'b0, 8'd5, 8'h33);
        step();
        check("s2_trig_first", sound2_trig, 32'h33);
        drive(1'b0, 1'b1, 1'b0, 8'd5, 8'hCC);
        step();
        check("s2_trig_second", sound2_trig, 32'hCC);
        check("s2_level", sound2, 32'hCC);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 59) == 0);
            port_wr      = 1'($urandom_range(0, 1));
            port_rd      = 1'($urandom_range(0, 1));
            port_addr    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 7));
            port_wdata   = 8'($urandom);
            inp0         = 8'($urandom);
            inp1         = 8'($urandom);
            inp2         = 8'($urandom);
            shift_result = 8'($urandom);
            step();
        end
        idle();
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter XLEN, default 8, data width of the CPU port bus and of the shift register data path.
REQ-002 Parameter WDOG_LIMIT, default 16'd60000, cycle count without a port-6 write before watchdog timeout.
REQ-003 clk  in  1  single system clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 port_addr  in  8  CPU IN/OUT port number.
REQ-006 port_wdata  in  XLEN  OUT data.
REQ-007 port_wr  in  1  one-cycle OUT strobe.
REQ-008 port_rd  in  1  one-cycle IN strobe.
REQ-009 port_rdata  out  XLEN  IN data, registered.
REQ-010 port_rdata_valid  out  1  one-cycle pulse qualifying port_rdata.
REQ-011 inp0, inp1, inp2  in  XLEN each  cabinet switch/DIP inputs.
REQ-012 shift_wdata  out  XLEN  data to shift register.
REQ-013 shift_wenable  out  1  one-cycle shift register write pulse.
REQ-014 shift_amount  out  3  latched shift amount.
REQ-015 shift_result  in  XLEN  shift register output.
REQ-016 sound1, sound2  out  XLEN each  latched sound port levels.
REQ-017 sound1_trig, sound2_trig  out  XLEN each  per-bit rising-edge pulses.
REQ-018 wdog_timeout  out  1  sticky watchdog expiry flag.

Function
REQ-019 The block SHALL decode the full 8-bit port_addr; unmapped OUT writes SHALL change no state.
REQ-020 OUT 2: shift_amount SHALL take port_wdata[2:0] on the next edge; bits above 2 ignored.
REQ-021 OUT 4: shift_wdata SHALL take port_wdata and shift_wenable SHALL be high for exactly the following cycle (latency 1); shift_wdata SHALL hold between writes.
REQ-022 OUT 3: sound1 SHALL take port_wdata; sound1_trig SHALL equal port_wdata & ~old sound1 for exactly one cycle, else 0.
REQ-023 OUT 5: identical to REQ-022 for sound2/sound2_trig.
REQ-024 OUT 6: watchdog counter SHALL clear to 0 and wdog_timeout SHALL clear on the next edge.
REQ-025 Watchdog counter SHALL increment each cycle, saturating at WDOG_LIMIT; wdog_timeout SHALL assert the cycle the count reaches WDOG_LIMIT and stay high until OUT 6 or rst.
REQ-026 IN: port_rdata and port_rdata_valid SHALL update one cycle after port_rd; addr 0/1/2 -> inp0/inp1/inp2, addr 3 -> shift_result, other addr -> 0 with valid still pulsed.
REQ-027 Inputs and shift_result SHALL be sampled in the port_rd cycle; port_rdata SHALL hold its value until the next port_rd.
REQ-028 Simultaneous port_wr and port_rd SHALL both be serviced; IN 3 concurrent with OUT 2 or OUT 4 SHALL return shift_result as presented that cycle (pre-update).
REQ-029 Back-to-back strobes on consecutive cycles SHALL each be serviced with no loss; two consecutive OUT 4 SHALL give two consecutive shift_wenable cycles.

Reset
REQ-030 On rst: port_rdata, shift_wdata, sound1, sound2, both trig buses = 0; shift_amount = 0; port_rdata_valid, shift_wenable, wdog_timeout = 0; watchdog counter = 0.
REQ-031 rst SHALL override any strobe in the same cycle; no pulse from that strobe SHALL appear afterwards.

Structure
REQ-032 Package io_port_pkg SHALL hold the port number constants (INP0=0, INP1=1, INP2/SHIFT_AMT=2, SHIFT_RES/SOUND1=3, SHIFT_DATA=4, SOUND2=5, WATCHDOG=6) and default WDOG_LIMIT.
REQ-033 One sub-module sound_port_latch (level register plus edge-pulse generation) SHALL be instantiated twice, for ports 3 and 5.

Verification
REQ-034 OUT 2 data 0xFD, then OUT 4 0xAB -> shift_amount=5 next cycle; shift_wdata=0xAB, shift_wenable high exactly one cycle.
REQ-035 OUT 3 0x05, then OUT 3 0x0F -> sound1_trig=0x05 one cycle, then 0x0A one cycle; sound1=0x0F.
REQ-036 inp1=0x81, shift_result=0x3C; IN 1 then IN 3 then IN 9 -> port_rdata 0x81, 0x3C, 0x00, each with one-cycle valid.
REQ-037 WDOG_LIMIT=10, no OUT 6 -> wdog_timeout high on 10th cycle after reset, stays high; OUT 6 -> clears next cycle.
REQ-038 rst asserted in same cycle as OUT 4 0x55 -> shift_wenable stays 0, shift_wdata=0x00.
